// File: rtl/pc_gen_unit_pkg.sv
// Shared definitions for the fetch-stage PC generator: next-PC opcode
// encodings, default reset/exception vectors and the branch-offset helper.
package pc_gen_unit_pkg;

  // Next-PC selection resolved by the ID stage
  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } npc_op_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

  // Sign-extend a 16-bit branch immediate and scale it to a byte offset
  function automatic logic signed [31:0] br_offset(input logic [15:0] imm16);
    br_offset = signed'({{14{imm16[15]}}, imm16, 2'b00});
  endfunction

endpackage

// File: rtl/pc_gen_unit_btb_dm.sv
// Direct-mapped branch target buffer: one combinational lookup port and one
// write/invalidate port. Valid bits are reset; tag and target storage are not.
// A write and a lookup at the same index in one cycle see the old contents.
module btb_dm
  import pc_gen_unit_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] lk_pc,
  output logic          lk_hit,
  output logic [AW-1:0] lk_tgt,
  input  logic          wr_en,
  input  logic          clr_en,
  input  logic [AW-1:0] wr_pc,
  input  logic [AW-1:0] wr_tgt
);

  localparam int IB = $clog2(DEPTH);
  localparam int TW = AW - IB - 2;

  logic [DEPTH-1:0] valid_q;
  logic [TW-1:0]    tag_q [DEPTH];
  logic [AW-1:0]    tgt_q [DEPTH];

  logic [IB-1:0] lk_idx;
  logic [IB-1:0] wr_idx;
  logic [TW-1:0] lk_tag;
  logic [TW-1:0] wr_tag;
  logic          unused_lsb;

  assign lk_idx     = lk_pc[IB+1:2];
  assign lk_tag     = lk_pc[AW-1:IB+2];
  assign wr_idx     = wr_pc[IB+1:2];
  assign wr_tag     = wr_pc[AW-1:IB+2];
  // Word-aligned indexing ignores the byte-offset bits
  assign unused_lsb = ^{lk_pc[1:0], wr_pc[1:0]};

  assign lk_hit = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign lk_tgt = tgt_q[lk_idx];

  // Valid bits: invalidate has priority, write sets the entry live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clr_en) begin
      valid_q[wr_idx] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/target payload: no reset needed, qualified by the valid bit
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      tgt_q[wr_idx] <= wr_tgt;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator for the 5-stage MIPS pipeline. Owns the PC
// register, resolves the ID-stage next PC, detects mispredicts and applies
// exception / mispredict / stall / predicted-fetch priority.
// Optional feature: define PC_BTB_EN to add a direct-mapped BTB (btb_dm) that
// predicts taken control flow at fetch; without it every taken transfer
// redirects and fetch always predicts PC+4.
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter int          AW        = 32,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int          BTB_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_i,
  input  logic          exc_i,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_pc_i,
  input  logic [1:0]    id_npc_op_i,
  input  logic [25:0]   id_imm_i,
  input  logic [AW-1:0] id_jr_addr_i,
  input  logic          id_pred_taken_i,
  input  logic [AW-1:0] id_pred_tgt_i,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] pc_plus4_o,
  output logic          pred_taken_o,
  output logic [AW-1:0] pred_tgt_o,
  output logic          redirect_o,
  output logic          misalign_o
);

  // Elaboration-time parameter sanity
  if ((AW < 29) || (AW > 32)) begin : g_aw_chk
    $error("pc_gen_unit: AW must be in 29..32");
  end
  if ((BTB_DEPTH < 2) || ((BTB_DEPTH & (BTB_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("pc_gen_unit: BTB_DEPTH must be a power of two >= 2");
  end

  localparam logic [AW-1:0] PC_STEP = {{(AW-3){1'b0}}, 3'b100};

  logic [AW-1:0]        pc_q;
  logic [AW-1:0]        pc_d;
  logic [AW-1:0]        id_pc_plus4;
  logic [AW-1:0]        actual_npc;
  logic [AW-1:0]        expected_npc;
  logic signed [31:0]   br_off_w;
  logic [AW-1:0]        br_off;
  logic                 mispredict;

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + PC_STEP;
  assign misalign_o = |pc_q[1:0];

  assign id_pc_plus4 = id_pc_i + PC_STEP;
  assign br_off_w    = br_offset(id_imm_i[15:0]);
  assign br_off      = br_off_w[AW-1:0];

  // Resolve the true successor of the instruction sitting in ID
  always_comb begin
    actual_npc = id_pc_plus4;
    case (npc_op_e'(id_npc_op_i))
      NPC_BRANCH: actual_npc = id_pc_plus4 + br_off;
      NPC_JUMP:   actual_npc = {id_pc_plus4[AW-1:28], id_imm_i, 2'b00};
      NPC_JR:     actual_npc = id_jr_addr_i;
      default:    actual_npc = id_pc_plus4;
    endcase
  end

  // Compare against what fetch assumed when this instruction was fetched
  assign expected_npc = id_pred_taken_i ? id_pred_tgt_i : id_pc_plus4;
  assign mispredict   = id_valid_i & ~stall_i & (actual_npc != expected_npc);
  assign redirect_o   = exc_i | mispredict;

`ifdef PC_BTB_EN
  logic          btb_hit;
  logic [AW-1:0] btb_tgt;
  logic          btb_upd;
  logic          btb_wr;
  logic          btb_clr;

  // Train only on live, unstalled, non-excepting ID instructions
  assign btb_upd = id_valid_i & ~stall_i & ~exc_i;
  assign btb_wr  = btb_upd & (id_npc_op_i != NPC_PLUS4);
  assign btb_clr = btb_upd & (id_npc_op_i == NPC_PLUS4) & id_pred_taken_i;

  btb_dm #(
    .AW    (AW),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk    (clk),
    .rst_n  (rst_n),
    .lk_pc  (pc_q),
    .lk_hit (btb_hit),
    .lk_tgt (btb_tgt),
    .wr_en  (btb_wr),
    .clr_en (btb_clr),
    .wr_pc  (id_pc_i),
    .wr_tgt (actual_npc)
  );

  assign pred_taken_o = btb_hit;
  assign pred_tgt_o   = btb_hit ? btb_tgt : pc_plus4_o;
`else
  assign pred_taken_o = 1'b0;
  assign pred_tgt_o   = pc_plus4_o;
`endif

  // Next-PC priority: exception, mispredict repair, stall hold, predicted fetch
  always_comb begin
    pc_d = pred_tgt_o;
    if (exc_i) begin
      pc_d = EXC_VEC[AW-1:0];
    end else if (mispredict) begin
      pc_d = actual_npc;
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VEC[AW-1:0];
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule
